i2c_master_byte: RTL and testbench

//  Single-byte I2C master transaction engine (START, 7-bit address + R/W, one data byte, STOP).

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_master_byte.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_byte.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: state encoding,
// quarter-bit phase names and default field widths.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_ADDR  = 4'd2,
    S_AACK  = 4'd3,
    S_WDATA = 4'd4,
    S_WACK  = 4'd5,
    S_RDATA = 4'd6,
    S_RNACK = 4'd7,
    S_STOP  = 4'd8
  } state_t;

  localparam logic [1:0] P_SETUP  = 2'd0;
  localparam logic [1:0] P_RISE   = 2'd1;
  localparam logic [1:0] P_SAMPLE = 2'd2;
  localparam logic [1:0] P_FALL   = 2'd3;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, {addr,rw}, one data byte, STOP, paced by a
// quarter-bit tick. Drives open-drain enables; all outputs are registered.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLK_STRETCH = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic [3:0]        state_dbg
);

  state_t            state, state_nxt;
  logic [1:0]        phase, phase_nxt;
  logic [2:0]        bitcnt, bitcnt_nxt;
  logic [ADDR_W:0]   frame_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept, hold, adv, smp_en, scl_low;
  logic              scl_d, sda_d, busy_d, done_d, ack_err_d;
  logic [DATA_W-1:0] rdata_d;

  // Handshake: start is a request sampled every clk; it is accepted only in
  // IDLE (tick not needed), and busy acknowledges it one clk later. While busy,
  // start is dropped, never queued.
  assign accept = (state == S_IDLE) && start;

  // A slave holding SCL low while we have released it freezes the bit.
  assign hold   = (CLK_STRETCH != 0) && ((phase == P_RISE) || (phase == P_SAMPLE)) && !scl_i;
  assign adv    = tick && !hold && (state != S_IDLE);
  assign smp_en = adv && (phase == P_SAMPLE);

  assign state_dbg = state;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= S_IDLE;
      phase   <= P_SETUP;
      bitcnt  <= 3'd7;
      frame_q <= '0;
      wdata_q <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      bitcnt <= bitcnt_nxt;
      if (accept) begin
        frame_q <= {addr, rw};
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    if (accept) begin
      state_nxt  = S_START;
      phase_nxt  = P_SETUP;
      bitcnt_nxt = 3'd7;
    end else if (adv) begin
      phase_nxt = phase + 2'd1;
      if (phase == P_FALL) begin
        case (state)
          S_START: state_nxt = S_ADDR;
          S_ADDR: begin
            bitcnt_nxt = bitcnt - 3'd1;
            if (bitcnt == 3'd0) state_nxt = S_AACK;
          end
          // ack_err was updated at the sample phase of this bit, so it is the address ACK.
          S_AACK:  state_nxt = ack_err ? S_STOP : (frame_q[0] ? S_RDATA : S_WDATA);
          S_WDATA: begin
            bitcnt_nxt = bitcnt - 3'd1;
            if (bitcnt == 3'd0) state_nxt = S_WACK;
          end
          S_WACK:  state_nxt = S_STOP;
          S_RDATA: begin
            bitcnt_nxt = bitcnt - 3'd1;
            if (bitcnt == 3'd0) state_nxt = S_RNACK;
          end
          S_RNACK: state_nxt = S_STOP;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Line levels are decoded from the upcoming state/phase so the registered
  // enables line up with the state register.
  always_comb begin
    scl_d   = 1'b0;
    sda_d   = 1'b0;
    scl_low = (phase_nxt == P_SETUP) || (phase_nxt == P_FALL);
    case (state_nxt)
      S_START: begin
        scl_d = (phase_nxt == P_FALL);
        sda_d = (phase_nxt == P_SAMPLE) || (phase_nxt == P_FALL);
      end
      S_ADDR: begin
        scl_d = scl_low;
        sda_d = ~frame_q[bitcnt_nxt];
      end
      S_WDATA: begin
        scl_d = scl_low;
        sda_d = ~wdata_q[bitcnt_nxt];
      end
      S_AACK, S_WACK, S_RDATA, S_RNACK: scl_d = scl_low;
      S_STOP: begin
        scl_d = (phase_nxt == P_SETUP);
        sda_d = (phase_nxt == P_SETUP) || (phase_nxt == P_RISE);
      end
      default: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
    endcase

    busy_d = (state_nxt != S_IDLE);
    done_d = adv && (phase == P_FALL) && (state == S_STOP);

    ack_err_d = ack_err;
    if (accept) ack_err_d = 1'b0;
    else if (smp_en && ((state == S_AACK) || (state == S_WACK)) && sda_i) ack_err_d = 1'b1;

    rdata_d = rdata;
    if (smp_en && (state == S_RDATA)) rdata_d = {rdata[DATA_W-2:0], sda_i};
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      scl_oe  <= scl_d;
      sda_oe  <= sda_d;
      busy    <= busy_d;
      done    <= done_d;
      ack_err <= ack_err_d;
      rdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: a behavioural open-drain slave on the bus plus a
// transaction-level model of the expected bit stream, latency and status.
module tb_i2c_master_byte;

  logic       clk = 1'b0;
  logic       res, tick, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic [3:0] state_dbg;

  logic       scl_hold, sl_pull, scl_line, sda_line;
  logic       sl_ack_addr, sl_ack_data, sl_rw;
  logic [7:0] sl_rdata;
  logic [2:0] ri;

  int  compared = 0, mismatched = 0;
  int  tick_cnt = 0, div = 0;
  int  fall_cnt = 0, stop_cnt = 0;
  bit  in_txn = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [0:0] exp_q[$];
  logic [0:0] obs_q[$];
  logic [7:0] exp_rdata = 8'h00;

  assign scl_line = !scl_oe && !scl_hold;
  assign sda_line = !sda_oe && !sl_pull;

  i2c_master_byte #(.ADDR_W(7), .DATA_W(8), .CLK_STRETCH(1)) dut (
    .clk(clk), .res(res), .tick(tick), .start(start), .addr(addr), .rw(rw),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_line), .sda_i(sda_line),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      tick = (div == 0);
    end
  end

  always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

  // ---------------- bus monitor + slave ----------------
  always @(scl_line or sda_line or res) begin
    if (!res) begin
      in_txn   = 0;
      fall_cnt = 0;
    end else begin
      if (prev_scl && scl_line && prev_sda && !sda_line) begin
        in_txn   = 1;
        fall_cnt = 0;
      end
      if (prev_scl && scl_line && !prev_sda && sda_line && in_txn) begin
        in_txn = 0;
        stop_cnt++;
      end
      if (prev_scl && !scl_line) fall_cnt++;
      if (!prev_scl && scl_line && in_txn) begin
        obs_q.push_back(!sda_oe);
        if (fall_cnt == 8) sl_rw = sda_line;
      end
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  // Bit on the bus is fall_cnt-1: 8 = address ACK, 9..16 = read data, 17 = write ACK.
  always_comb begin
    sl_pull = 1'b0;
    ri      = 3'(17 - fall_cnt);
    if (in_txn && sl_ack_addr) begin
      if (fall_cnt == 9) sl_pull = 1'b1;
      else if (sl_rw && fall_cnt >= 10 && fall_cnt <= 17) sl_pull = !sl_rdata[ri];
      else if (!sl_rw && fall_cnt == 18) sl_pull = sl_ack_data;
    end
  end

  // ---------------- driver / scoreboard ----------------
  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] wd, output int t0);
    @(negedge clk);
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = tick_cnt;
    addr = ~a; rw = ~r; wdata = ~wd;
  endtask

  task automatic run_txn(input string name, input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic acka, input logic ackd, input logic [7:0] rd,
                         input bit stretch, input bit repulse);
    int t0, lat, exp_lat, sst, ts, stops0, extra_done;
    bit seen, pulsed;
    logic exp_err;
    logic [7:0] fr;
    sl_ack_addr = acka; sl_ack_data = ackd; sl_rdata = rd; sl_rw = r;
    exp_q.delete();
    fr = {a, r};
    for (int i = 7; i >= 0; i--) exp_q.push_back(fr[i]);
    exp_q.push_back(1'b1);
    if (acka) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(r ? 1'b1 : wd[i]);
      exp_q.push_back(1'b1);
    end
    exp_q.push_back(1'b0);
    exp_lat = acka ? 80 : 44;
    if (stretch) exp_lat += 10;
    exp_err = !acka || (!r && !ackd);
    if (r && acka) exp_rdata = rd;
    stops0 = stop_cnt;
    obs_q.delete();
    sst = 0; ts = 0; seen = 0; pulsed = 0; lat = 0;

    launch(a, r, wd, t0);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end

    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (stretch) begin
        case (sst)
          0: if (fall_cnt == 4) begin scl_hold = 1'b1; sst = 1; end
          1: if (!scl_oe) begin ts = tick_cnt; sst = 2; end
          2: if (tick_cnt - ts >= 10) begin scl_hold = 1'b0; sst = 3; end
          default: ;
        endcase
      end
      if (start) start = 1'b0;
      else if (repulse && !pulsed && (tick_cnt - t0 >= 20)) begin
        start = 1'b1; addr = ~a; wdata = ~wd; pulsed = 1;
      end
      if (done) begin
        seen = 1;
        lat  = tick_cnt - t0;
        compared++;
        if (busy !== 1'b0) begin
          mismatched++;
          $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        compared++;
        if (ack_err !== exp_err) begin
          mismatched++;
          $display("FAIL %s ack_err: got %b want %b", name, ack_err, exp_err);
        end
        compared++;
        if (rdata !== exp_rdata) begin
          mismatched++;
          $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
        end
      end
    end
    scl_hold = 1'b0;
    start    = 1'b0;

    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s done_timeout: got no done want done", name);
      @(negedge clk); res = 1'b0;
      @(negedge clk); res = 1'b1;
      return;
    end
    if (lat != exp_lat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d ticks", name, lat, exp_lat);
    end

    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done_width: got %b want 0", name, done);
    end
    compared++;
    if (stop_cnt != stops0 + 1) begin
      mismatched++;
      $display("FAIL %s stop_count: got %0d want %0d", name, stop_cnt - stops0, 1);
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s bit_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (obs_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL %s bit%0d: got %b want %b", name, i, obs_q[i], exp_q[i]);
        end
      end
    end

    if (repulse) begin
      extra_done = 0;
      repeat (400) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      compared++;
      if (extra_done != 0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL %s extra_done: got %0d dones busy=%b want 0 dones busy=0", name, extra_done, busy);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    res = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0; scl_hold = 1'b0;
    sl_ack_addr = 1'b0; sl_ack_data = 1'b0; sl_rdata = '0; sl_rw = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({scl_oe, sda_oe, busy, done, ack_err} !== 5'b0 || rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got scl=%b sda=%b busy=%b done=%b err=%b rdata=%h want all 0",
               scl_oe, sda_oe, busy, done, ack_err, rdata);
    end
    res = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({scl_oe, sda_oe, busy, done} !== 4'b0) begin
      mismatched++;
      $display("FAIL idle_outputs: got scl=%b sda=%b busy=%b done=%b want 0", scl_oe, sda_oe, busy, done);
    end
  endtask

  task automatic test_write();
    run_txn("write", 7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 0);
  endtask

  task automatic test_addr_nack();
    run_txn("addr_nack", 7'h22, 1'b0, 8'($urandom), 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_data_nack();
    run_txn("data_nack", 7'h11, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_read();
    run_txn("read", 7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A, 0, 0);
  endtask

  task automatic test_start_ignored();
    run_txn("restart_ignored", 7'h2B, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 0, 1);
  endtask

  task automatic test_reset_mid();
    int t0;
    sl_ack_addr = 1'b1; sl_ack_data = 1'b1; sl_rdata = 8'h00;
    launch(7'h50, 1'b0, 8'hA5, t0);
    for (int c = 0; c < 2000 && (tick_cnt - t0 < 40); c++) @(negedge clk);
    res = 1'b0;
    #1;
    compared++;
    if ({scl_oe, sda_oe, busy, done, ack_err} !== 5'b0 || rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_mid: got scl=%b sda=%b busy=%b done=%b err=%b rdata=%h want all 0",
               scl_oe, sda_oe, busy, done, ack_err, rdata);
    end
    exp_rdata = 8'h00;
    @(negedge clk);
    res = 1'b1;
    repeat (4) @(negedge clk);
    run_txn("after_reset", 7'h44, 1'b1, 8'h00, 1'b1, 1'b1, 8'h96, 0, 0);
  endtask

  task automatic test_stretch();
    run_txn("stretch", 7'h5D, 1'b0, 8'h69, 1'b1, 1'b1, 8'h00, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_txn("random", 7'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom), 0, 0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_nack();
    test_read();
    test_data_nack();
    test_start_ignored();
    test_reset_mid();
    test_stretch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
